// File: rtl/gem_cluster_window_mapper.sv
// Latches a frame of GEM clusters and maps each one, one per clock, through
// programmable pad/roll LUTs to CSC wiregroup and halfstrip matching windows.
module gem_cluster_window_mapper #(
  parameter int NCLUSTERS    = 8,
  parameter int STRIPBITS    = 8,
  parameter int WIREBITS     = 7,
  parameter int MAXWIRE      = 47,
  parameter int MAXPAD       = 191,
  parameter int MINKEYHSME1B = 0,
  parameter int MAXKEYHSME1B = 127,
  parameter int MINKEYHSME1A = 128,
  parameter int MAXKEYHSME1A = 223,
  parameter int ME1A_ROLL    = 7,
  parameter int INVALIDHS    = 224
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           evenchamber,
  input  logic [4:0]                     gem_clct_deltahs,
  input  logic [2:0]                     gem_alct_deltawire,
  input  logic                           start,
  input  logic [14*NCLUSTERS-1:0]        cluster_in,
  input  logic [NCLUSTERS-1:0]           vpf_in,
  input  logic [3*NCLUSTERS-1:0]         roll_in,
  input  logic [8*NCLUSTERS-1:0]         pad_in,
  input  logic [3*NCLUSTERS-1:0]         size_in,
  input  logic                           lut_wen,
  input  logic [2:0]                     lut_sel,
  input  logic [7:0]                     lut_adr,
  input  logic [7:0]                     lut_wdata,
  input  logic                           overflow_clr,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [14*NCLUSTERS-1:0]        cluster_out,
  output logic [NCLUSTERS-1:0]           vpf_out,
  output logic [NCLUSTERS-1:0]           me1a_out,
  output logic [WIREBITS*NCLUSTERS-1:0]  wire_lo_out,
  output logic [WIREBITS*NCLUSTERS-1:0]  wire_hi_out,
  output logic [WIREBITS*NCLUSTERS-1:0]  wire_mi_out,
  output logic [STRIPBITS*NCLUSTERS-1:0] hs_lo_out,
  output logic [STRIPBITS*NCLUSTERS-1:0] hs_hi_out,
  output logic [STRIPBITS*NCLUSTERS-1:0] hs_mi_out
);
  localparam int IW = (NCLUSTERS > 1) ? $clog2(NCLUSTERS) : 1;
  localparam int CW = $clog2(NCLUSTERS + 2);
  localparam int HW = STRIPBITS + 1;
  localparam int WW = WIREBITS + 1;
  localparam logic [CW-1:0] NISSUE    = CW'(NCLUSTERS);
  localparam logic [CW-1:0] DRAIN_END = CW'(NCLUSTERS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NCLUSTERS - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          latch_en, ovf_set;

  logic [13:0] cluster_q [NCLUSTERS];
  logic        vpf_q     [NCLUSTERS];
  logic [2:0]  roll_q    [NCLUSTERS];
  logic [7:0]  pad_q     [NCLUSTERS];
  logic [2:0]  size_q    [NCLUSTERS];
  logic        even_q;
  logic [4:0]  dhs_q;
  logic [2:0]  dw_q;

  logic [STRIPBITS-1:0] me1a_lut  [2][256];
  logic [STRIPBITS-1:0] me1b_lut  [2][256];
  logic [WIREBITS-1:0]  wg_lo_lut [2][8];
  logic [WIREBITS-1:0]  wg_hi_lut [2][8];

  assign busy = (state_q == RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter runs past the last issue for two extra cycles to drain the pipeline.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          latch_en = 1'b1;
        end
      end
      RUN: begin
        ovf_set = start;
        if (cnt_q == DRAIN_END) state_d = IDLE;
        else                    cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)             overflow <= 1'b0;
    else if (overflow_clr) overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (latch_en) begin
      even_q <= evenchamber;
      dhs_q  <= gem_clct_deltahs;
      dw_q   <= gem_alct_deltawire;
      for (int i = 0; i < NCLUSTERS; i++) begin
        cluster_q[i] <= cluster_in[14*i +: 14];
        vpf_q[i]     <= vpf_in[i];
        roll_q[i]    <= roll_in[3*i +: 3];
        pad_q[i]     <= pad_in[8*i +: 8];
        size_q[i]    <= size_in[3*i +: 3];
      end
    end
  end

  // LUTs are locked while a frame is in flight so a frame sees one consistent table.
  always_ff @(posedge clock) begin
    if (lut_wen && !busy) begin
      case (lut_sel[2:1])
        2'd0:    me1a_lut[lut_sel[0]][lut_adr]       <= lut_wdata[STRIPBITS-1:0];
        2'd1:    me1b_lut[lut_sel[0]][lut_adr]       <= lut_wdata[STRIPBITS-1:0];
        2'd2:    wg_lo_lut[lut_sel[0]][lut_adr[2:0]] <= lut_wdata[WIREBITS-1:0];
        default: wg_hi_lut[lut_sel[0]][lut_adr[2:0]] <= lut_wdata[WIREBITS-1:0];
      endcase
    end
  end

  logic          issue;
  logic [IW-1:0] k;
  logic [8:0]    pad_sum;
  logic [7:0]    pad_lo, pad_hi;
  logic          roll_is_me1a;

  assign issue = (state_q == RUN) && (cnt_q < NISSUE);
  assign k     = cnt_q[IW-1:0];

  always_comb begin
    pad_sum      = {1'b0, pad_q[k]} + {6'b0, size_q[k]};
    pad_lo       = vpf_q[k] ? pad_q[k] : 8'd0;
    pad_hi       = (pad_sum > 9'(MAXPAD)) ? 8'(MAXPAD) : pad_sum[7:0];
    roll_is_me1a = (roll_q[k] == 3'(ME1A_ROLL));
  end

  logic                 s1_valid;
  logic [IW-1:0]        s1_idx;
  logic                 s1_me1a;
  logic [STRIPBITS-1:0] s1_hs_a, s1_hs_b;
  logic [WIREBITS-1:0]  s1_wg_a, s1_wg_b;

  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= issue;
  end

  always_ff @(posedge clock) begin
    s1_idx  <= k;
    s1_me1a <= roll_is_me1a;
    s1_hs_a <= roll_is_me1a ? me1a_lut[even_q][pad_lo] : me1b_lut[even_q][pad_lo];
    s1_hs_b <= roll_is_me1a ? me1a_lut[even_q][pad_hi] : me1b_lut[even_q][pad_hi];
    s1_wg_a <= wg_lo_lut[even_q][roll_q[k]];
    s1_wg_b <= wg_hi_lut[even_q][roll_q[k]];
  end

  logic [HW-1:0] hs_min, hs_max, dhs_x, hs_lo_x, hs_hi_x;
  logic [HW-1:0] hs_lo_w, hs_hi_w, hs_mi_w;
  logic [WW-1:0] dw_x, wg_lo_x, wg_hi_x;
  logic [WW-1:0] wire_lo_w, wire_hi_w, wire_mi_w;

  // Midpoints are taken from the clamped window, not the raw LUT values.
  always_comb begin
    hs_min  = s1_me1a ? HW'(MINKEYHSME1A) : HW'(MINKEYHSME1B);
    hs_max  = s1_me1a ? HW'(MAXKEYHSME1A) : HW'(MAXKEYHSME1B);
    dhs_x   = HW'(dhs_q);
    hs_lo_x = (s1_hs_a < s1_hs_b) ? {1'b0, s1_hs_a} : {1'b0, s1_hs_b};
    hs_hi_x = (s1_hs_a < s1_hs_b) ? {1'b0, s1_hs_b} : {1'b0, s1_hs_a};
    hs_lo_w = (hs_lo_x > hs_min + dhs_x) ? hs_lo_x - dhs_x : hs_min;
    hs_hi_w = (hs_hi_x + dhs_x > hs_max) ? hs_max : hs_hi_x + dhs_x;
    hs_mi_w = HW'(hs_lo_w[STRIPBITS-1:1]) + HW'(hs_hi_w[STRIPBITS-1:1])
            + HW'(hs_lo_w[0] | hs_hi_w[0]);

    dw_x      = WW'(dw_q);
    wg_lo_x   = (s1_wg_a < s1_wg_b) ? {1'b0, s1_wg_a} : {1'b0, s1_wg_b};
    wg_hi_x   = (s1_wg_a < s1_wg_b) ? {1'b0, s1_wg_b} : {1'b0, s1_wg_a};
    wire_lo_w = (wg_lo_x > dw_x) ? wg_lo_x - dw_x : '0;
    wire_hi_w = (wg_hi_x + dw_x < WW'(MAXWIRE)) ? wg_hi_x + dw_x : WW'(MAXWIRE);
    wire_mi_w = WW'(wire_lo_w[WIREBITS-1:1]) + WW'(wire_hi_w[WIREBITS-1:1])
              + WW'(wire_lo_w[0] | wire_hi_w[0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done        <= 1'b0;
      cluster_out <= '0;
      vpf_out     <= '0;
      me1a_out    <= '0;
      wire_lo_out <= '0;
      wire_hi_out <= '0;
      wire_mi_out <= '0;
      hs_lo_out   <= '0;
      hs_hi_out   <= '0;
      hs_mi_out   <= '0;
    end else begin
      done <= s1_valid && (s1_idx == LAST_IDX);
      if (s1_valid) begin
        cluster_out[14*s1_idx +: 14] <= cluster_q[s1_idx];
        if (vpf_q[s1_idx]) begin
          vpf_out[s1_idx]                          <= 1'b1;
          me1a_out[s1_idx]                         <= s1_me1a;
          wire_lo_out[WIREBITS*s1_idx +: WIREBITS]  <= wire_lo_w[WIREBITS-1:0];
          wire_hi_out[WIREBITS*s1_idx +: WIREBITS]  <= wire_hi_w[WIREBITS-1:0];
          wire_mi_out[WIREBITS*s1_idx +: WIREBITS]  <= wire_mi_w[WIREBITS-1:0];
          hs_lo_out[STRIPBITS*s1_idx +: STRIPBITS] <= hs_lo_w[STRIPBITS-1:0];
          hs_hi_out[STRIPBITS*s1_idx +: STRIPBITS] <= hs_hi_w[STRIPBITS-1:0];
          hs_mi_out[STRIPBITS*s1_idx +: STRIPBITS] <= hs_mi_w[STRIPBITS-1:0];
        end else begin
          vpf_out[s1_idx]                          <= 1'b0;
          me1a_out[s1_idx]                         <= 1'b0;
          wire_lo_out[WIREBITS*s1_idx +: WIREBITS]  <= '0;
          wire_hi_out[WIREBITS*s1_idx +: WIREBITS]  <= '0;
          wire_mi_out[WIREBITS*s1_idx +: WIREBITS]  <= '0;
          hs_lo_out[STRIPBITS*s1_idx +: STRIPBITS] <= STRIPBITS'(INVALIDHS);
          hs_hi_out[STRIPBITS*s1_idx +: STRIPBITS] <= STRIPBITS'(INVALIDHS);
          hs_mi_out[STRIPBITS*s1_idx +: STRIPBITS] <= STRIPBITS'(INVALIDHS);
        end
      end
    end
  end
endmodule

// File: tb/tb_gem_cluster_window_mapper.sv
// Directed bench for gem_cluster_window_mapper: window arithmetic, clamps,
// frame timing, overflow, mid-frame reset and LUT write locking.
module tb_gem_cluster_window_mapper;
  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic evenchamber = 1'b0;
  logic [4:0] gem_clct_deltahs = '0;
  logic [2:0] gem_alct_deltawire = '0;
  logic start = 1'b0;
  logic [14*N-1:0] cluster_in = '0;
  logic [N-1:0] vpf_in = '0;
  logic [3*N-1:0] roll_in = '0;
  logic [8*N-1:0] pad_in = '0;
  logic [3*N-1:0] size_in = '0;
  logic lut_wen = 1'b0;
  logic [2:0] lut_sel = '0;
  logic [7:0] lut_adr = '0;
  logic [7:0] lut_wdata = '0;
  logic overflow_clr = 1'b0;
  logic busy, done, overflow;
  logic [14*N-1:0] cluster_out;
  logic [N-1:0] vpf_out, me1a_out;
  logic [7*N-1:0] wire_lo_out, wire_hi_out, wire_mi_out;
  logic [8*N-1:0] hs_lo_out, hs_hi_out, hs_mi_out;

  int n_checks = 0;
  int n_fail = 0;

  gem_cluster_window_mapper dut (
    .clock(clock), .reset(reset), .evenchamber(evenchamber),
    .gem_clct_deltahs(gem_clct_deltahs), .gem_alct_deltawire(gem_alct_deltawire),
    .start(start), .cluster_in(cluster_in), .vpf_in(vpf_in), .roll_in(roll_in),
    .pad_in(pad_in), .size_in(size_in), .lut_wen(lut_wen), .lut_sel(lut_sel),
    .lut_adr(lut_adr), .lut_wdata(lut_wdata), .overflow_clr(overflow_clr),
    .busy(busy), .done(done), .overflow(overflow), .cluster_out(cluster_out),
    .vpf_out(vpf_out), .me1a_out(me1a_out), .wire_lo_out(wire_lo_out),
    .wire_hi_out(wire_hi_out), .wire_mi_out(wire_mi_out), .hs_lo_out(hs_lo_out),
    .hs_hi_out(hs_hi_out), .hs_mi_out(hs_mi_out)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] hsf(input logic [8*N-1:0] v, input int k);
    return v[8*k +: 8];
  endfunction

  function automatic logic [6:0] wf(input logic [7*N-1:0] v, input int k);
    return v[7*k +: 7];
  endfunction

  function automatic logic [13:0] cf(input logic [14*N-1:0] v, input int k);
    return v[14*k +: 14];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_lut(input logic [2:0] sel, input logic [7:0] adr, input logic [7:0] data);
    lut_wen = 1'b1; lut_sel = sel; lut_adr = adr; lut_wdata = data;
    tick();
    lut_wen = 1'b0;
  endtask

  task automatic clear_frame();
    vpf_in = '0; roll_in = '0; pad_in = '0; size_in = '0;
    for (int k = 0; k < N; k++) cluster_in[14*k +: 14] = 14'h100 + 14'(k);
  endtask

  task automatic set_slot(input int k, input logic [2:0] roll, input logic [7:0] pad, input logic [2:0] size);
    vpf_in[k] = 1'b1;
    roll_in[3*k +: 3] = roll;
    pad_in[8*k +: 8] = pad;
    size_in[3*k +: 3] = size;
  endtask

  task automatic setup_base();
    clear_frame();
    set_slot(0, 3'd2, 8'd10, 3'd2);
    set_slot(7, 3'd2, 8'd10, 3'd2);
  endtask

  task automatic pulse_start(input logic even, input logic [4:0] dhs, input logic [2:0] dw);
    evenchamber = even; gem_clct_deltahs = dhs; gem_alct_deltawire = dw;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_done_timeout: done=%b required 1", name, done); end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (hs_lo_out !== '0) begin n_fail++; $display("[TB] FAIL reset_hs_lo: got %h expected 0", hs_lo_out); end
    n_checks++; if (hs_mi_out !== '0) begin n_fail++; $display("[TB] FAIL reset_hs_mi: got %h expected 0", hs_mi_out); end
    n_checks++; if (wire_hi_out !== '0) begin n_fail++; $display("[TB] FAIL reset_wire_hi: got %h expected 0", wire_hi_out); end
    n_checks++; if (cluster_out !== '0) begin n_fail++; $display("[TB] FAIL reset_cluster: got %h expected 0", cluster_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_me1b_window();
    write_lut(3'd3, 8'd10, 8'd20);
    write_lut(3'd3, 8'd12, 8'd24);
    write_lut(3'd5, 8'd2, 8'd10);
    write_lut(3'd7, 8'd2, 8'd17);
    clear_frame();
    set_slot(0, 3'd2, 8'd10, 3'd2);
    pulse_start(1'b1, 5'd4, 3'd2);
    wait_done("me1b");
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd16) begin n_fail++; $display("[TB] FAIL me1b_hs_lo: got %0d expected 16", hsf(hs_lo_out, 0)); end
    n_checks++; if (hsf(hs_hi_out, 0) !== 8'd28) begin n_fail++; $display("[TB] FAIL me1b_hs_hi: got %0d expected 28", hsf(hs_hi_out, 0)); end
    n_checks++; if (hsf(hs_mi_out, 0) !== 8'd22) begin n_fail++; $display("[TB] FAIL me1b_hs_mi: got %0d expected 22", hsf(hs_mi_out, 0)); end
    n_checks++; if (wf(wire_lo_out, 0) !== 7'd8) begin n_fail++; $display("[TB] FAIL me1b_wire_lo: got %0d expected 8", wf(wire_lo_out, 0)); end
    n_checks++; if (wf(wire_hi_out, 0) !== 7'd19) begin n_fail++; $display("[TB] FAIL me1b_wire_hi: got %0d expected 19", wf(wire_hi_out, 0)); end
    n_checks++; if (wf(wire_mi_out, 0) !== 7'd14) begin n_fail++; $display("[TB] FAIL me1b_wire_mi: got %0d expected 14", wf(wire_mi_out, 0)); end
    n_checks++; if (me1a_out[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL me1b_me1a: got %b expected 0", me1a_out[0]); end
    n_checks++; if (vpf_out[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL me1b_vpf: got %b expected 1", vpf_out[0]); end
    n_checks++; if (cf(cluster_out, 0) !== 14'h100) begin n_fail++; $display("[TB] FAIL me1b_cluster: got %h expected 100", cf(cluster_out, 0)); end
    n_checks++; if (hsf(hs_lo_out, 1) !== 8'd224) begin n_fail++; $display("[TB] FAIL me1b_invalid_slot1: got %0d expected 224", hsf(hs_lo_out, 1)); end
  endtask

  task automatic test_me1a_window();
    write_lut(3'd0, 8'd0, 8'd130);
    write_lut(3'd4, 8'd7, 8'd3);
    write_lut(3'd6, 8'd7, 8'd5);
    clear_frame();
    set_slot(0, 3'd7, 8'd0, 3'd0);
    pulse_start(1'b0, 5'd5, 3'd0);
    wait_done("me1a");
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd128) begin n_fail++; $display("[TB] FAIL me1a_hs_lo: got %0d expected 128", hsf(hs_lo_out, 0)); end
    n_checks++; if (hsf(hs_hi_out, 0) !== 8'd135) begin n_fail++; $display("[TB] FAIL me1a_hs_hi: got %0d expected 135", hsf(hs_hi_out, 0)); end
    n_checks++; if (hsf(hs_mi_out, 0) !== 8'd132) begin n_fail++; $display("[TB] FAIL me1a_hs_mi: got %0d expected 132", hsf(hs_mi_out, 0)); end
    n_checks++; if (me1a_out[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL me1a_flag: got %b expected 1", me1a_out[0]); end
    n_checks++; if (wf(wire_lo_out, 0) !== 7'd3) begin n_fail++; $display("[TB] FAIL me1a_wire_lo: got %0d expected 3", wf(wire_lo_out, 0)); end
    n_checks++; if (wf(wire_hi_out, 0) !== 7'd5) begin n_fail++; $display("[TB] FAIL me1a_wire_hi: got %0d expected 5", wf(wire_hi_out, 0)); end
    n_checks++; if (wf(wire_mi_out, 0) !== 7'd4) begin n_fail++; $display("[TB] FAIL me1a_wire_mi: got %0d expected 4", wf(wire_mi_out, 0)); end
  endtask

  task automatic test_saturation();
    write_lut(3'd3, 8'd190, 8'd100);
    write_lut(3'd3, 8'd191, 8'd110);
    write_lut(3'd3, 8'd195, 8'd250);
    write_lut(3'd5, 8'd3, 8'd40);
    write_lut(3'd7, 8'd3, 8'd46);
    clear_frame();
    set_slot(0, 3'd3, 8'd190, 3'd5);
    pulse_start(1'b1, 5'd0, 3'd2);
    wait_done("sat");
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd100) begin n_fail++; $display("[TB] FAIL sat_hs_lo: got %0d expected 100", hsf(hs_lo_out, 0)); end
    n_checks++; if (hsf(hs_hi_out, 0) !== 8'd110) begin n_fail++; $display("[TB] FAIL sat_pad_hi_191: got %0d expected 110", hsf(hs_hi_out, 0)); end
    n_checks++; if (hsf(hs_mi_out, 0) !== 8'd105) begin n_fail++; $display("[TB] FAIL sat_hs_mi: got %0d expected 105", hsf(hs_mi_out, 0)); end
    n_checks++; if (wf(wire_lo_out, 0) !== 7'd38) begin n_fail++; $display("[TB] FAIL sat_wire_lo: got %0d expected 38", wf(wire_lo_out, 0)); end
    n_checks++; if (wf(wire_hi_out, 0) !== 7'd47) begin n_fail++; $display("[TB] FAIL sat_wire_hi_clamp: got %0d expected 47", wf(wire_hi_out, 0)); end
    n_checks++; if (wf(wire_mi_out, 0) !== 7'd43) begin n_fail++; $display("[TB] FAIL sat_wire_mi: got %0d expected 43", wf(wire_mi_out, 0)); end
  endtask

  task automatic test_timing_overflow();
    setup_base();
    pulse_start(1'b1, 5'd4, 3'd2);
    for (int c = 1; c <= 12; c++) begin
      n_checks++; if (busy !== (c <= 10)) begin n_fail++; $display("[TB] FAIL timing_busy c=%0d: got %b expected %b", c, busy, (c <= 10)); end
      n_checks++; if (done !== (c == 10)) begin n_fail++; $display("[TB] FAIL timing_done c=%0d: got %b expected %b", c, done, (c == 10)); end
      if (c == 2) begin
        n_checks++; if (hsf(hs_lo_out, 0) !== 8'd100) begin n_fail++; $display("[TB] FAIL timing_slot0_early: got %0d expected 100", hsf(hs_lo_out, 0)); end
      end
      if (c == 3) begin
        n_checks++; if (hsf(hs_lo_out, 0) !== 8'd16) begin n_fail++; $display("[TB] FAIL timing_slot0_valid: got %0d expected 16", hsf(hs_lo_out, 0)); end
      end
      if (c == 9) begin
        n_checks++; if (hsf(hs_lo_out, 7) !== 8'd224) begin n_fail++; $display("[TB] FAIL timing_slot7_early: got %0d expected 224", hsf(hs_lo_out, 7)); end
      end
      if (c == 10) begin
        n_checks++; if (hsf(hs_lo_out, 7) !== 8'd16) begin n_fail++; $display("[TB] FAIL timing_slot7_valid: got %0d expected 16", hsf(hs_lo_out, 7)); end
      end
      if (c == 3) begin
        pad_in[7:0] = 8'd12; size_in[2:0] = 3'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd16) begin n_fail++; $display("[TB] FAIL ovf_frame1_hs_lo: got %0d expected 16", hsf(hs_lo_out, 0)); end
    n_checks++; if (hsf(hs_hi_out, 0) !== 8'd28) begin n_fail++; $display("[TB] FAIL ovf_frame1_hs_hi: got %0d expected 28", hsf(hs_hi_out, 0)); end
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_midframe();
    setup_base();
    pulse_start(1'b1, 5'd4, 3'd2);
    for (int c = 1; c <= 9; c++) begin
      if (c == 6) begin
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (hs_lo_out !== '0) begin n_fail++; $display("[TB] FAIL midrst_hs_lo: got %h expected 0", hs_lo_out); end
        n_checks++; if (hs_hi_out !== '0) begin n_fail++; $display("[TB] FAIL midrst_hs_hi: got %h expected 0", hs_hi_out); end
        n_checks++; if (wire_lo_out !== '0) begin n_fail++; $display("[TB] FAIL midrst_wire_lo: got %h expected 0", wire_lo_out); end
        n_checks++; if (cluster_out !== '0) begin n_fail++; $display("[TB] FAIL midrst_cluster: got %h expected 0", cluster_out); end
        n_checks++; if (vpf_out !== '0) begin n_fail++; $display("[TB] FAIL midrst_vpf: got %h expected 0", vpf_out); end
      end
      if (c >= 6) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_no_done c=%0d: got %b expected 0", c, done); end
      end
      if (c == 5) reset = 1'b1;
      tick();
    end
    pulse_start(1'b1, 5'd4, 3'd2);
    wait_done("midrst_rerun");
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd16) begin n_fail++; $display("[TB] FAIL midrst_lut_hs_lo: got %0d expected 16", hsf(hs_lo_out, 0)); end
    n_checks++; if (wf(wire_hi_out, 0) !== 7'd19) begin n_fail++; $display("[TB] FAIL midrst_lut_wire_hi: got %0d expected 19", wf(wire_hi_out, 0)); end
  endtask

  task automatic test_invalid_lut_lock();
    setup_base();
    pulse_start(1'b1, 5'd4, 3'd2);
    tick();
    lut_wen = 1'b1; lut_sel = 3'd3; lut_adr = 8'd10; lut_wdata = 8'd99;
    tick();
    lut_wen = 1'b0;
    wait_done("invalid");
    n_checks++; if (hsf(hs_lo_out, 3) !== 8'd224) begin n_fail++; $display("[TB] FAIL inv_hs_lo: got %0d expected 224", hsf(hs_lo_out, 3)); end
    n_checks++; if (hsf(hs_hi_out, 3) !== 8'd224) begin n_fail++; $display("[TB] FAIL inv_hs_hi: got %0d expected 224", hsf(hs_hi_out, 3)); end
    n_checks++; if (hsf(hs_mi_out, 3) !== 8'd224) begin n_fail++; $display("[TB] FAIL inv_hs_mi: got %0d expected 224", hsf(hs_mi_out, 3)); end
    n_checks++; if (wf(wire_lo_out, 3) !== 7'd0) begin n_fail++; $display("[TB] FAIL inv_wire_lo: got %0d expected 0", wf(wire_lo_out, 3)); end
    n_checks++; if (wf(wire_hi_out, 3) !== 7'd0) begin n_fail++; $display("[TB] FAIL inv_wire_hi: got %0d expected 0", wf(wire_hi_out, 3)); end
    n_checks++; if (wf(wire_mi_out, 3) !== 7'd0) begin n_fail++; $display("[TB] FAIL inv_wire_mi: got %0d expected 0", wf(wire_mi_out, 3)); end
    n_checks++; if (vpf_out[3] !== 1'b0) begin n_fail++; $display("[TB] FAIL inv_vpf: got %b expected 0", vpf_out[3]); end
    n_checks++; if (cf(cluster_out, 3) !== 14'h103) begin n_fail++; $display("[TB] FAIL inv_cluster_pass: got %h expected 103", cf(cluster_out, 3)); end
    pulse_start(1'b1, 5'd4, 3'd2);
    wait_done("lock_rerun");
    n_checks++; if (hsf(hs_lo_out, 0) !== 8'd16) begin n_fail++; $display("[TB] FAIL lut_lock_hs_lo: got %0d expected 16", hsf(hs_lo_out, 0)); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_me1b_window();
    test_me1a_window();
    test_saturation();
    test_timing_overflow();
    test_reset_midframe();
    test_invalid_lut_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
